// File: rtl/counter_din_cond.sv
// Input conditioner: 2-FF sync, glitch filter and minimum-hold FSM feeding the edge-handshake synchronizer.
// Define COUNTER_DIN_DROP_CNT_EN to build the lost-edge counter; otherwise o_drop_cnt is tied to 0.
module counter_din_cond #(
   parameter int unsigned FILTER_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES   = 16,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             i_clk_din,
   input  logic             i_rstn_din,
   input  logic             i_raw,
   input  logic             i_drop_clr,
   output logic             o_din,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_drop_cnt
);

   localparam int unsigned FLT_W  = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
   localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(FILTER_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   // Encoding chosen so o_din and o_busy come straight from state flops (glitch-free).
   typedef enum logic [1:0] {
      LOW_IDLE  = 2'b00,
      LOW_HOLD  = 2'b01,
      HIGH_IDLE = 2'b10,
      HIGH_HOLD = 2'b11
   } state_t;

   state_t            state, state_nxt;
   logic              s1, s2, filtered;
   logic [FLT_W-1:0]  flt_cnt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic              flt_accept;
   logic              hold_exit;

   assign flt_accept = (s2 != filtered) && (flt_cnt == FLT_LAST);
   assign o_din      = state[1];
   assign o_busy     = state[0];

   always_ff @(posedge i_clk_din or negedge i_rstn_din) begin
      if (!i_rstn_din) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         filtered <= 1'b0;
         flt_cnt  <= '0;
      end else begin
         s1 <= i_raw;
         s2 <= s1;
         if (s2 == filtered) begin
            flt_cnt <= '0;
         end else if (flt_accept) begin
            filtered <= s2;
            flt_cnt  <= '0;
         end else begin
            flt_cnt <= flt_cnt + FLT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk_din or negedge i_rstn_din) begin
      if (!i_rstn_din) begin
         state    <= LOW_IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      hold_exit = 1'b0;
      case (state)
         LOW_IDLE: begin
            if (filtered) begin
               state_nxt = HIGH_HOLD;
               hold_nxt  = HOLD_LOAD;
            end
         end
         HIGH_IDLE: begin
            if (!filtered) begin
               state_nxt = LOW_HOLD;
               hold_nxt  = HOLD_LOAD;
            end
         end
         HIGH_HOLD: begin
            if (hold_cnt == '0) begin
               hold_exit = 1'b1;
               if (!filtered) begin
                  state_nxt = LOW_HOLD;
                  hold_nxt  = HOLD_LOAD;
               end else begin
                  state_nxt = HIGH_IDLE;
               end
            end else begin
               hold_nxt = hold_cnt - HOLD_W'(1);
            end
         end
         LOW_HOLD: begin
            if (hold_cnt == '0) begin
               hold_exit = 1'b1;
               if (filtered) begin
                  state_nxt = HIGH_HOLD;
                  hold_nxt  = HOLD_LOAD;
               end else begin
                  state_nxt = LOW_IDLE;
               end
            end else begin
               hold_nxt = hold_cnt - HOLD_W'(1);
            end
         end
         default: state_nxt = LOW_IDLE;
      endcase
   end

`ifdef COUNTER_DIN_DROP_CNT_EN
   logic [CNT_W-1:0] win_cnt, win_sum, lost;
   logic [CNT_W:0]   drop_sum;

   // win_sum folds in an edge accepted during the exit cycle; one net edge is deferred, not lost.
   always_comb begin
      win_sum = win_cnt;
      if (o_busy && flt_accept && (win_cnt != '1)) begin
         win_sum = win_cnt + CNT_W'(1);
      end
      lost     = win_sum - CNT_W'(filtered != o_din);
      drop_sum = {1'b0, o_drop_cnt} + {1'b0, lost};
   end

   always_ff @(posedge i_clk_din or negedge i_rstn_din) begin
      if (!i_rstn_din) begin
         win_cnt    <= '0;
         o_drop_cnt <= '0;
      end else begin
         if (hold_exit) begin
            win_cnt <= '0;
         end else if (o_busy) begin
            win_cnt <= win_sum;
         end
         if (i_drop_clr) begin
            o_drop_cnt <= '0;
         end else if (hold_exit) begin
            o_drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
         end
      end
   end
`else
   logic unused_drop;
   assign unused_drop = i_drop_clr ^ hold_exit;
   assign o_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_counter_din_cond.sv
// Scoreboard bench for counter_din_cond: three parameter sets, expected output events queued by stimulus
// and compared by a negedge monitor. Drop-count expectations follow COUNTER_DIN_DROP_CNT_EN.
module tb_counter_din_cond;

   typedef struct packed {
      logic [31:0] cyc;
      logic        din;
      logic        busy;
      logic [7:0]  drop;
   } ev_t;

`ifdef COUNTER_DIN_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn [3];
   logic        raw  [3];
   logic        clr  [3];
   logic        din  [3];
   logic        busy [3];
   logic [7:0]  d0, d1;
   logic [1:0]  d2;
   logic [9:0]  prev [3];
   int unsigned cyc = 0;
   int unsigned n_total = 0;
   int unsigned n_pass = 0;
   ev_t         q0[$], q1[$], q2[$];

   counter_din_cond #(.FILTER_CYCLES(4), .HOLD_CYCLES(16), .CNT_W(8)) u0 (
      .i_clk_din(clk), .i_rstn_din(rstn[0]), .i_raw(raw[0]), .i_drop_clr(clr[0]),
      .o_din(din[0]), .o_busy(busy[0]), .o_drop_cnt(d0));

   counter_din_cond #(.FILTER_CYCLES(4), .HOLD_CYCLES(32), .CNT_W(8)) u1 (
      .i_clk_din(clk), .i_rstn_din(rstn[1]), .i_raw(raw[1]), .i_drop_clr(clr[1]),
      .o_din(din[1]), .o_busy(busy[1]), .o_drop_cnt(d1));

   counter_din_cond #(.FILTER_CYCLES(4), .HOLD_CYCLES(16), .CNT_W(2)) u2 (
      .i_clk_din(clk), .i_rstn_din(rstn[2]), .i_raw(raw[2]), .i_drop_clr(clr[2]),
      .o_din(din[2]), .o_busy(busy[2]), .o_drop_cnt(d2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] dx(input int unsigned v);
      return DROP_EN ? 8'(v) : 8'd0;
   endfunction

   function automatic logic [7:0] drop_of(input int i);
      case (i)
         0:       return d0;
         1:       return d1;
         default: return {6'b0, d2};
      endcase
   endfunction

   function automatic int qsize(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic ev_t qhead(input int i);
      case (i)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic qpop(input int i);
      ev_t e;
      case (i)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
   endtask

   task automatic ev(input int i, input int unsigned c, input logic dn, input logic bs, input logic [7:0] dr);
      ev_t e;
      e = '{cyc: c, din: dn, busy: bs, drop: dr};
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic check_inst(input int i);
      ev_t        e;
      logic [9:0] act;
      act = {din[i], busy[i], drop_of(i)};
      e   = '0;
      if (qsize(i) != 0) e = qhead(i);
      if (qsize(i) != 0 && e.cyc <= cyc) begin
         qpop(i);
         n_total++;
         if (e.cyc == cyc && act == {e.din, e.busy, e.drop}) n_pass++;
         else $display("FAIL event u%0d cyc=%0d due=%0d: got din=%b busy=%b drop=%0d, want din=%b busy=%b drop=%0d",
                       i, cyc, e.cyc, act[9], act[8], act[7:0], e.din, e.busy, e.drop);
      end else if (act != prev[i]) begin
         n_total++;
         $display("FAIL unexpected_change u%0d cyc=%0d: got din=%b busy=%b drop=%0d, want din=%b busy=%b drop=%0d",
                  i, cyc, act[9], act[8], act[7:0], prev[i][9], prev[i][8], prev[i][7:0]);
      end
      prev[i] = act;
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) check_inst(i);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Alternating 6-cycle raw segments starting high; the last segment is left low.
   task automatic pattern(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         raw[i] = (k % 2 == 0);
         if (k != n - 1) tick(6);
      end
   endtask

   initial begin
      int unsigned t;
      ev_t         e;
      for (int i = 0; i < 3; i++) begin
         rstn[i] = 1'b0;
         raw[i]  = 1'b0;
         clr[i]  = 1'b0;
         prev[i] = '0;
      end
      tick(3);

      // Reset state and quiet idle after release
      t = cyc;
      for (int i = 0; i < 3; i++) begin
         ev(i, t, 0, 0, 0);
         ev(i, t + 50, 0, 0, 0);
         rstn[i] = 1'b1;
      end
      tick(50);

      // u0: 3-cycle glitch is rejected
      t = cyc;
      ev(0, t + 20, 0, 0, 0);
      raw[0] = 1'b1; tick(3); raw[0] = 1'b0;
      tick(20);

      // u0: rise and stay, then fall back
      t = cyc;
      ev(0, t + 7, 1, 1, 0); ev(0, t + 23, 1, 0, 0); ev(0, t + 40, 1, 0, 0);
      raw[0] = 1'b1; tick(40);
      t = cyc;
      ev(0, t + 7, 0, 1, 0); ev(0, t + 23, 0, 0, 0);
      raw[0] = 1'b0; tick(30);

      // u0: 10-cycle pulse is stretched to 16, fall forwarded straight into LOW_HOLD
      t = cyc;
      ev(0, t + 7, 1, 1, 0); ev(0, t + 23, 0, 1, 0); ev(0, t + 39, 0, 0, 0); ev(0, t + 45, 0, 0, 0);
      raw[0] = 1'b1; tick(10); raw[0] = 1'b0;
      tick(45);

      // u0: reset asserted mid-hold
      t = cyc;
      ev(0, t + 7, 1, 1, 0); ev(0, t + 10, 0, 0, 0); ev(0, t + 30, 0, 0, 0);
      raw[0] = 1'b1; tick(10);
      rstn[0] = 1'b0; raw[0] = 1'b0; tick(2);
      rstn[0] = 1'b1; tick(20);

      // u1: five edges inside a 32-cycle window -> four lost
      t = cyc;
      ev(1, t + 7, 1, 1, 0); ev(1, t + 39, 0, 1, dx(4)); ev(1, t + 71, 0, 0, dx(4));
      pattern(1, 6); tick(45);

      // u1: same again with clear on the increment cycle
      t = cyc;
      ev(1, t + 7, 1, 1, dx(4)); ev(1, t + 39, 0, 1, 0); ev(1, t + 71, 0, 0, 0);
      pattern(1, 6); tick(8);
      clr[1] = 1'b1; tick(1); clr[1] = 1'b0;
      tick(36);

      // u2: two lost per run with a 2-bit counter -> 2, then saturates at 3
      for (int r = 0; r < 3; r++) begin
         int unsigned base, after;
         base  = (r == 0) ? 0 : (r == 1) ? 2 : 3;
         after = (r == 0) ? 2 : 3;
         t = cyc;
         ev(2, t + 7, 1, 1, dx(base)); ev(2, t + 23, 1, 0, dx(after));
         ev(2, t + 25, 0, 1, dx(after)); ev(2, t + 41, 0, 0, dx(after));
         pattern(2, 4); tick(30);
      end

      tick(5);
      for (int i = 0; i < 3; i++) begin
         while (qsize(i) != 0) begin
            e = qhead(i);
            qpop(i);
            n_total++;
            $display("FAIL missing_event u%0d due=%0d: got nothing, want din=%b busy=%b drop=%0d",
                     i, e.cyc, e.din, e.busy, e.drop);
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
